// File: rtl/led_breathe_if.sv
`default_nettype none
// ============================================================================
// Module      : led_breathe_if
// Description : Control and status bundle of the breathing-LED block.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_breathe_if #(
  parameter int PWM_BITS = 8
);
  logic                EN;
  logic                TICK_IN;
  logic                LED;
  logic [PWM_BITS-1:0] DUTY;
  logic [2:0]          STATE;
  logic                CYCLE_DONE;

  modport master (
    output EN, TICK_IN,
    input  LED, DUTY, STATE, CYCLE_DONE
  );

  modport slave (
    input  EN, TICK_IN,
    output LED, DUTY, STATE, CYCLE_DONE
  );
endinterface
`default_nettype wire

// File: rtl/led_breathe.sv
`default_nettype none
// ============================================================================
// Module      : led_breathe
// Description : Tick-stepped ramp FSM driving a PWM LED (rise/hold/fall/hold).
// Revision    : 1.0 - initial release
// ============================================================================
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 16,
  parameter int HOLD_TICKS = 2
) (
  input  logic          CLK_100MHz,
  input  logic          RST,
  led_breathe_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int                  HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS+1)'(STEP);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                tick_q;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                led_q;
  logic [PWM_BITS:0]   sum;

  assign tick = bus.TICK_IN & ~tick_q;
  // One spare bit so the saturation check sees the carry out of the add.
  assign sum  = {1'b0, duty_q} + STEP_X;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!bus.EN) begin
      state_d = IDLE;
      duty_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RISE;
          duty_d  = '0;
          hold_d  = '0;
        end
        RISE: if (tick) begin
          if (sum >= {1'b0, MAX}) begin
            duty_d  = MAX;
            state_d = HOLD_HI;
            hold_d  = '0;
          end else begin
            duty_d = sum[PWM_BITS-1:0];
          end
        end
        HOLD_HI: if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = FALL;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        FALL: if (tick) begin
          if ({1'b0, duty_q} <= STEP_X) begin
            duty_d  = '0;
            state_d = HOLD_LO;
            hold_d  = '0;
          end else begin
            duty_d = duty_q - STEP_X[PWM_BITS-1:0];
          end
        end
        HOLD_LO: if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RISE;
            hold_d  = '0;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // tick_q resets high so a divider output already high at release is not a tick.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      tick_q  <= 1'b1;
      pwm_cnt <= '0;
      led_q   <= 1'b0;
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      tick_q  <= bus.TICK_IN;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led_q   <= (pwm_cnt < duty_q);
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign bus.LED        = led_q;
  assign bus.DUTY       = duty_q;
  assign bus.STATE      = state_q;
  assign bus.CYCLE_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_breathe.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_breathe
// Description : Self-checking bench for led_breathe against a tick-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_breathe;

  localparam int PWM_BITS   = 4;
  localparam int STEP       = 4;
  localparam int HOLD_TICKS = 2;
  localparam int MAXV       = (1 << PWM_BITS) - 1;
  localparam int PERIOD     = 1 << PWM_BITS;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  // Expected (duty, state, cycle_done) after each tick of one breathing cycle.
  int exp_duty[$];
  int exp_state[$];
  int exp_done[$];

  led_breathe_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_breathe #(
    .PWM_BITS  (PWM_BITS),
    .STEP      (STEP),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .CLK_100MHz(clk),
    .RST       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.CYCLE_DONE === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic measure_led(output int cnt);
    cnt = 0;
    repeat (PERIOD) begin
      step();
      if (bus.LED === 1'b1) cnt++;
    end
  endtask

  task automatic run_tick(input int idx, input int hi, input int lo);
    int cnt;
    bus.TICK_IN = 1'b1;
    step();
    check($sformatf("duty_t%0d", idx), 32'(bus.DUTY), exp_duty[idx]);
    check($sformatf("state_t%0d", idx), 32'(bus.STATE), exp_state[idx]);
    check($sformatf("done_t%0d", idx), 32'(bus.CYCLE_DONE), exp_done[idx]);
    step();
    check($sformatf("done_width_t%0d", idx), 32'(bus.CYCLE_DONE), 0);
    repeat (hi) step();
    bus.TICK_IN = 1'b0;
    repeat (lo) step();
    measure_led(cnt);
    check($sformatf("led_duty_t%0d", idx), cnt, exp_duty[idx]);
    check($sformatf("duty_stable_t%0d", idx), 32'(bus.DUTY), exp_duty[idx]);
  endtask

  initial begin
    int d;
    int base;

    d = 0;
    do begin
      d = (d + STEP > MAXV) ? MAXV : d + STEP;
      exp_duty.push_back(d); exp_state.push_back(d == MAXV ? 2 : 1); exp_done.push_back(0);
    end while (d != MAXV);
    for (int h = 0; h < HOLD_TICKS; h++) begin
      exp_duty.push_back(MAXV); exp_state.push_back(h == HOLD_TICKS - 1 ? 3 : 2); exp_done.push_back(0);
    end
    do begin
      d = (d - STEP < 0) ? 0 : d - STEP;
      exp_duty.push_back(d); exp_state.push_back(d == 0 ? 4 : 3); exp_done.push_back(0);
    end while (d != 0);
    for (int h = 0; h < HOLD_TICKS; h++) begin
      exp_duty.push_back(0); exp_state.push_back(h == HOLD_TICKS - 1 ? 1 : 4);
      exp_done.push_back(h == HOLD_TICKS - 1 ? 1 : 0);
    end

    // Reset with the divider output already high.
    rst = 1'b1; bus.EN = 1'b1; bus.TICK_IN = 1'b1;
    repeat (3) step();
    check("rst_state", 32'(bus.STATE), 0);
    check("rst_duty", 32'(bus.DUTY), 0);
    check("rst_led", 32'(bus.LED), 0);
    check("rst_done", 32'(bus.CYCLE_DONE), 0);
    rst = 1'b0;
    repeat (3) step();
    check("rel_state", 32'(bus.STATE), 1);
    check("rel_duty", 32'(bus.DUTY), 0);
    bus.TICK_IN = 1'b0;
    repeat (2) step();

    // One full breathing cycle with random tick spacing; first tick is long.
    done_cnt = 0;
    for (int i = 0; i < exp_duty.size(); i++)
      run_tick(i, (i == 0) ? 50 : $urandom_range(0, 7), $urandom_range(1, 6));
    check("done_pulses_cycle1", done_cnt, 1);

    // Ramp up and down to the FALL step at duty 7, then drop EN with a tick edge.
    for (int i = 0; i < exp_duty.size(); i++) begin
      run_tick(i, $urandom_range(0, 5), $urandom_range(1, 4));
      if (exp_state[i] == 3 && exp_duty[i] == 7) break;
    end
    check("pre_drop_duty", 32'(bus.DUTY), 7);
    bus.EN = 1'b0; bus.TICK_IN = 1'b1;
    step();
    check("endrop_state", 32'(bus.STATE), 0);
    check("endrop_duty", 32'(bus.DUTY), 0);
    step();
    check("endrop_led", 32'(bus.LED), 0);
    bus.TICK_IN = 1'b0;
    repeat (4) step();
    check("en_low_state", 32'(bus.STATE), 0);
    bus.EN = 1'b1;
    step();
    check("reen_state", 32'(bus.STATE), 1);
    check("reen_duty", 32'(bus.DUTY), 0);

    // Climb into HOLD_HI with hold_cnt=1, then reset on a tick edge.
    base = 0;
    while (!(exp_state[base] == 2 && base > 0 && exp_state[base-1] == 2)) begin
      run_tick(base, $urandom_range(0, 5), $urandom_range(1, 4));
      base++;
    end
    run_tick(base, $urandom_range(0, 5), $urandom_range(1, 4));
    check("prerst_state", 32'(bus.STATE), 2);
    rst = 1'b1; bus.TICK_IN = 1'b1;
    step();
    check("midrst_state", 32'(bus.STATE), 0);
    check("midrst_duty", 32'(bus.DUTY), 0);
    check("midrst_led", 32'(bus.LED), 0);
    check("midrst_done", 32'(bus.CYCLE_DONE), 0);
    rst = 1'b0;
    step();
    check("postrst_state", 32'(bus.STATE), 1);
    bus.TICK_IN = 1'b0;
    repeat (2) step();

    done_cnt = 0;
    for (int i = 0; i < exp_duty.size(); i++)
      run_tick(i, $urandom_range(0, 7), $urandom_range(1, 6));
    check("done_pulses_cycle2", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
